pipe_hazard_unit: RTL

//  Parametrised control pipeline plus hazard logic; successor to the single-stage MW control register.

---
 rtl/pipe_hazard_unit.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: control pipeline with load-use detection and forwarding selects (optional PERF_CNT_EN counters)
module pipe_hazard_unit #(
    parameter int STAGES = 2,
    parameter logic [1:0] WB_MEM = 2'b01,
    localparam int SELW = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       inst_d,
    input  logic              valid_d,
    input  logic              reg_wr,
    input  logic [1:0]        wb_sel,
    input  logic              stall_in,
    input  logic              flush_in,
    output logic              load_use,
    output logic [SELW-1:0]   fwd_rs1,
    output logic [SELW-1:0]   fwd_rs2,
    output logic [STAGES-1:0] stage_valid,
    output logic              reg_wr_wb,
    output logic [1:0]        wb_sel_wb,
    output logic [4:0]        rd_wb,
    output logic [2:0]        funct3_wb,
    output logic [6:0]        opcode_wb,
    output logic [31:0]       lu_cnt,
    output logic [31:0]       fl_cnt
);
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] reg_wr_q;
    logic [STAGES-1:0] prod;
    logic [1:0]        wb_sel_q [STAGES];
    logic [4:0]        rd_q     [STAGES];
    logic [2:0]        funct3_q [STAGES];
    logic [6:0]        opcode_q [STAGES];
    logic [6:0]        op;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic              use1;
    logic              use2;

    assign op  = inst_d[6:0];
    assign rs1 = inst_d[19:15];
    assign rs2 = inst_d[24:20];

    // which register sources the decoded opcode actually reads
    always_comb begin
        use1 = 1'b0;
        use2 = 1'b0;
        case (op)
            7'b0010011, 7'b0000011, 7'b1100111: use1 = 1'b1;
            7'b0110011, 7'b0100011, 7'b1100011: begin
                use1 = 1'b1;
                use2 = 1'b1;
            end
            default: ;
        endcase
    end

    // hazard detection and forwarding; the downward scan lets the youngest match win
    always_comb begin
        prod    = valid_q & reg_wr_q;
        fwd_rs1 = '0;
        fwd_rs2 = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            prod[k] = prod[k] && (rd_q[k] != 5'd0);
            if (prod[k] && use1 && rd_q[k] == rs1)
                fwd_rs1 = (k == 0 && wb_sel_q[0] == WB_MEM) ? '0 : SELW'(k + 1);
            if (prod[k] && use2 && rd_q[k] == rs2)
                fwd_rs2 = (k == 0 && wb_sel_q[0] == WB_MEM) ? '0 : SELW'(k + 1);
        end
        load_use = valid_d && prod[0] && wb_sel_q[0] == WB_MEM &&
                   ((use1 && rd_q[0] == rs1) || (use2 && rd_q[0] == rs2));
    end

    // stage registers: shift when not stalled, flush kills stage 1 even under stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= '0;
            reg_wr_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                wb_sel_q[k] <= '0;
                rd_q[k]     <= '0;
                funct3_q[k] <= '0;
                opcode_q[k] <= '0;
            end
        end else if (stall_in) begin
            if (flush_in) valid_q[0] <= 1'b0;
        end else begin
            for (int k = STAGES - 1; k >= 1; k--) begin
                valid_q[k]  <= valid_q[k-1];
                reg_wr_q[k] <= reg_wr_q[k-1];
                wb_sel_q[k] <= wb_sel_q[k-1];
                rd_q[k]     <= rd_q[k-1];
                funct3_q[k] <= funct3_q[k-1];
                opcode_q[k] <= opcode_q[k-1];
            end
            valid_q[0]  <= valid_d && !flush_in && !load_use;
            reg_wr_q[0] <= reg_wr;
            wb_sel_q[0] <= wb_sel;
            rd_q[0]     <= inst_d[11:7];
            funct3_q[0] <= inst_d[14:12];
            opcode_q[0] <= op;
        end
    end

    assign stage_valid = valid_q;
    assign reg_wr_wb   = reg_wr_q[STAGES-1] && valid_q[STAGES-1];
    assign wb_sel_wb   = wb_sel_q[STAGES-1];
    assign rd_wb       = rd_q[STAGES-1];
    assign funct3_wb   = funct3_q[STAGES-1];
    assign opcode_wb   = opcode_q[STAGES-1];

`ifdef PERF_CNT_EN
    // event counters for stall and flush activity, wrapping naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lu_cnt <= '0;
            fl_cnt <= '0;
        end else begin
            if (load_use && !stall_in) lu_cnt <= lu_cnt + 32'd1;
            if (flush_in) fl_cnt <= fl_cnt + 32'd1;
        end
    end
`else
    assign lu_cnt = '0;
    assign fl_cnt = '0;
`endif
endmodule
